// File: rtl/dieu_khien_ena_pkg.sv
// Shared types and constants for the enable-rate controller.
//   level_t    : 2-bit committed/target rate level
//   LVL_*      : rate level codes (0=1 Hz .. 3=100 Hz)
//   state_t    : commit FSM encoding (IDLE=0, WAIT=1)
//   step_level : applies one up/down press to a level with silent saturation
package dieu_khien_ena_pkg;

  typedef logic [1:0] level_t;

  localparam level_t LVL_1HZ   = 2'd0;
  localparam level_t LVL_20HZ  = 2'd1;
  localparam level_t LVL_50HZ  = 2'd2;
  localparam level_t LVL_100HZ = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Simultaneous up and down cancel; saturation at either end is silent.
  function automatic level_t step_level(input level_t cur, input logic up, input logic dn);
    level_t nxt;
    nxt = cur;
    if (up && !dn && (cur != LVL_100HZ)) begin
      nxt = cur + 2'd1;
    end else if (dn && !up && (cur != LVL_1HZ)) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dieu_khien_ena_chong_doi.sv
// chong_doi: button conditioning for one raw push-button.
//   ckht   : system clock
//   rst_n  : synchronous active-low reset
//   ena_db : debounce sampling strobe
//   btn    : raw active-high button, asynchronous to ckht
//   press  : one-cycle pulse on each accepted 0->1 debounced transition
module chong_doi #(
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic ckht,
  input  logic rst_n,
  input  logic ena_db,
  input  logic btn,
  output logic press
);

  localparam logic [3:0] DB_MAX = 4'(DB_SAMPLES);

  logic       sync1;
  logic       sync2;
  logic       db_state;
  logic       db_prev;
  logic [3:0] cnt;

  always_ff @(posedge ckht) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_state <= 1'b0;
      db_prev  <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_state;
      if (ena_db) begin
        // Counter only advances on consecutive samples that disagree with
        // the accepted level; any agreeing sample restarts the run.
        if (sync2 != db_state) begin
          if (cnt + 4'd1 == DB_MAX) begin
            db_state <= ~db_state;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

  assign press = db_state & ~db_prev;

endmodule

// File: rtl/dieu_khien_ena.sv
// dieu_khien_ena: selects one of four divider enables, with the rate stepped
// by debounced up/down buttons and committed only on an active-rate tick.
//   ckht                         : system clock
//   rst_n                        : synchronous active-low reset
//   ena1hz/20hz/50hz/100hz       : one-cycle rate pulses from the divider
//   ena_db                       : debounce sampling strobe
//   btn_up, btn_dn               : raw active-high buttons
//   ena_out                      : selected enable, registered (1-cycle latency)
//   level                        : committed rate level
//   pending                      : a requested level awaits commit
module dieu_khien_ena
  import dieu_khien_ena_pkg::*;
#(
  parameter int unsigned DB_SAMPLES = 4,
  parameter level_t      LEVEL_RST  = LVL_1HZ
) (
  input  logic       ckht,
  input  logic       rst_n,
  input  logic       ena1hz,
  input  logic       ena20hz,
  input  logic       ena50hz,
  input  logic       ena100hz,
  input  logic       ena_db,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic       ena_out,
  output logic [1:0] level,
  output logic       pending
);

  logic   up_press;
  logic   dn_press;
  logic   tick;
  level_t target;
  level_t target_nxt;
  level_t level_nxt;
  state_t state;
  state_t state_nxt;

  chong_doi #(.DB_SAMPLES(DB_SAMPLES)) u_cd_up (
    .ckht   (ckht),
    .rst_n  (rst_n),
    .ena_db (ena_db),
    .btn    (btn_up),
    .press  (up_press)
  );

  chong_doi #(.DB_SAMPLES(DB_SAMPLES)) u_cd_dn (
    .ckht   (ckht),
    .rst_n  (rst_n),
    .ena_db (ena_db),
    .btn    (btn_dn),
    .press  (dn_press)
  );

  always_ff @(posedge ckht) begin
    if (!rst_n) begin
      state   <= IDLE;
      level   <= LEVEL_RST;
      target  <= LEVEL_RST;
      ena_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      target  <= target_nxt;
      // Mux uses the pre-update level, so the committing old-rate tick is
      // still forwarded and no new-rate pulse from the commit cycle leaks.
      ena_out <= tick;
    end
  end

  always_comb begin
    tick       = 1'b0;
    level_nxt  = level;
    target_nxt = step_level(target, up_press, dn_press);
    state_nxt  = state;
    pending    = (state == WAIT);

    case (level)
      LVL_1HZ:   tick = ena1hz;
      LVL_20HZ:  tick = ena20hz;
      LVL_50HZ:  tick = ena50hz;
      LVL_100HZ: tick = ena100hz;
      default:   tick = 1'b0;
    endcase

    // Commit takes the target held before any same-cycle press; that press
    // then lands on the new target and the state is re-derived from the
    // post-commit pair, which covers IDLE->WAIT, WAIT->IDLE (cancel or
    // commit) and commit-then-re-enter-WAIT in one rule.
    if ((state == WAIT) && tick) begin
      level_nxt = target;
    end
    state_nxt = (target_nxt != level_nxt) ? WAIT : IDLE;
  end

endmodule

// File: tb/tb_dieu_khien_ena.sv
module tb_dieu_khien_ena;

  logic       ckht;
  logic       rst_n;
  logic       ena1hz;
  logic       ena20hz;
  logic       ena50hz;
  logic       ena100hz;
  logic       ena_db;
  logic       btn_up;
  logic       btn_dn;
  logic       ena_out;
  logic [1:0] level;
  logic       pending;

  localparam logic [1:0] LEVEL_RST = 2'd0;

  int   total = 0;
  int   bad   = 0;
  logic sbq[$];

  // Bench-side expectation of committed level and any outstanding request.
  logic [1:0] mdl_level  = LEVEL_RST;
  logic [1:0] mdl_target = LEVEL_RST;
  logic       mdl_pend   = 1'b0;

  dieu_khien_ena #(.DB_SAMPLES(4), .LEVEL_RST(LEVEL_RST)) dut (
    .ckht     (ckht),
    .rst_n    (rst_n),
    .ena1hz   (ena1hz),
    .ena20hz  (ena20hz),
    .ena50hz  (ena50hz),
    .ena100hz (ena100hz),
    .ena_db   (ena_db),
    .btn_up   (btn_up),
    .btn_dn   (btn_dn),
    .ena_out  (ena_out),
    .level    (level),
    .pending  (pending)
  );

  initial ckht = 1'b0;
  always #5 ckht = ~ckht;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: r = {100,50,20,1 Hz}. Expected ena_out is queued from the
  // bench's level before the edge and popped/compared just after it.
  task automatic cyc(input logic [3:0] r, input logic db, input logic up,
                     input logic dn, input logic rst);
    logic e;
    rst_n    = ~rst;
    ena1hz   = r[0];
    ena20hz  = r[1];
    ena50hz  = r[2];
    ena100hz = r[3];
    ena_db   = db;
    btn_up   = up;
    btn_dn   = dn;
    sbq.push_back(rst ? 1'b0 : r[mdl_level]);
    @(posedge ckht);
    #1;
    if (rst) begin
      mdl_level  = LEVEL_RST;
      mdl_target = LEVEL_RST;
      mdl_pend   = 1'b0;
    end else if (mdl_pend && r[mdl_level]) begin
      mdl_level = mdl_target;
      mdl_pend  = 1'b0;
    end
    e = sbq.pop_front();
    chk("ena_out", 8'(ena_out), 8'(e));
    chk("level_track", 8'(level), 8'(mdl_level));
  endtask

  // One debounce sample: value held 3 cycles so it has crossed the synchroniser.
  task automatic sample(input logic up, input logic dn);
    cyc(4'b0000, 1'b0, up, dn, 1'b0);
    cyc(4'b0000, 1'b0, up, dn, 1'b0);
    cyc(4'b0000, 1'b1, up, dn, 1'b0);
  endtask

  task automatic press(input logic up, input logic dn);
    for (int unsigned i = 0; i < 6; i++) sample(up, dn);
    for (int unsigned i = 0; i < 6; i++) sample(1'b0, 1'b0);
  endtask

  task automatic request(input logic up, input logic dn, input logic [1:0] tgt);
    press(up, dn);
    mdl_target = tgt;
    mdl_pend   = (tgt != mdl_level);
    chk("pending_req", 8'(pending), 8'(mdl_pend));
  endtask

  initial begin
    int n_in;
    int n_out;
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_level", 8'(level), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_ena_out", 8'(ena_out), 8'd0);

    // 1: level 0 forwards only 1 Hz
    for (int i = 0; i < 40; i++) begin
      cyc({(i % 2 == 0), (i % 4 == 1), (i % 10 == 3), (i == 7 || i == 30)},
          1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 2: bounced up press -> single request, commit on 1 Hz tick
    sample(1'b1, 1'b0); sample(1'b0, 1'b0); sample(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) sample(1'b0, 1'b0);
    mdl_target = 2'd1;
    mdl_pend   = 1'b1;
    chk("bounce_pending", 8'(pending), 8'd1);
    chk("bounce_level", 8'(level), 8'd0);
    cyc(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);  // old tick forwarded, coincident 20 Hz not
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("commit1_level", 8'(level), 8'd1);
    chk("commit1_pending", 8'(pending), 8'd0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // back to level 0: inactive 1 Hz tick must not commit
    request(1'b0, 1'b1, 2'd0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("inactive_no_commit", 8'(pending), 8'd1);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("down_level", 8'(level), 8'd0);

    // 3: four ups saturate at 3, single jump 0->3
    for (int i = 0; i < 4; i++) begin
      request(1'b1, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
      chk("sat_level_hold", 8'(level), 8'd0);
    end
    cyc(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_level", 8'(level), 8'd3);
    request(1'b0, 1'b1, 2'd2);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("level2", 8'(level), 8'd2);

    // 4: up then down before a 50 Hz tick cancels
    request(1'b1, 1'b0, 2'd3);
    request(1'b0, 1'b1, 2'd2);
    chk("cancel_level", 8'(level), 8'd2);
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 30; i++) begin
      cyc({(i % 2 == 0), (i % 5 == 2), (i % 7 == 1), (i % 11 == 0)},
          1'b0, 1'b0, 1'b0, 1'b0);
      n_in  += int'(i % 5 == 2);
      n_out += int'(ena_out);
    end
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_out += int'(ena_out);
    chk("count50", 8'(n_out), 8'(n_in));
    chk("cancel_stays", 8'(level), 8'd2);

    // 5: to level 1, then coincident up+down leaves target alone
    request(1'b0, 1'b1, 2'd1);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("level1", 8'(level), 8'd1);
    request(1'b1, 1'b1, 2'd1);
    chk("both_level", 8'(level), 8'd1);
    request(1'b0, 1'b1, 2'd0);   // only pends if target was still 1
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_target", 8'(level), 8'd0);
    request(1'b1, 1'b0, 2'd1);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset while waiting (level 1, target 3)
    request(1'b1, 1'b0, 2'd2);
    request(1'b1, 1'b0, 2'd3);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstw_level", 8'(level), 8'(LEVEL_RST));
    chk("rstw_pending", 8'(pending), 8'd0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstw_no_commit", 8'(level), 8'(LEVEL_RST));
    chk("rstw_pending2", 8'(pending), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
